// File: rtl/div_bla_16_if.sv
// Handshake and operand/result bundle for the 16-bit restoring divider div_bla_16.
interface div_bla_16_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        dbz;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, dbz);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, dbz);
endinterface

// File: rtl/div_bla_16.sv
// Iterative 16-bit unsigned restoring divider with a 4-group borrow-lookahead trial subtractor.
// Optional divide-by-zero short-cut enabled by defining DIV_ZERO_TRAP_EN.
module div_bla_16 (
  input  logic         clk,
  input  logic         rst,
  div_bla_16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic [15:0] b_reg;
  logic [15:0] q_reg;
  logic [15:0] r_reg;
  logic [15:0] quot_reg;
  logic [15:0] rem_reg;
  logic        accept;
  logic        last_iter;
  logic [16:0] s_val;
  logic [16:0] t_val;
  logic [15:0] q_next;
  logic [15:0] r_next;

  // Returns {borrow_out, difference[15:0]} of s - b using LCU-style group borrows.
  function automatic logic [16:0] bla_sub(input logic [16:0] s, input logic [16:0] b);
    logic [16:0] g, p;
    logic [15:0] bi, diff;
    logic [3:0]  gg, gp;
    logic [4:0]  c;
    g = ~s & b;
    p = ~(s ^ b);
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    c[0] = 1'b0;
    c[1] = gg[0] | (gp[0] & c[0]);
    c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
    c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c[0]);
    c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
         | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
    for (int k = 0; k < 4; k++) begin
      bi[4*k] = c[k];
      for (int j = 1; j < 4; j++)
        bi[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & bi[4*k+j-1]);
    end
    diff = s[15:0] ^ b[15:0] ^ bi;
    return {g[16] | (p[16] & c[4]), diff};
  endfunction

  assign accept    = bus.start && (state == IDLE || state == DONE);
  assign last_iter = (state == BUSY) && (count == 4'd15);

  // R is kept at 16 bits: after any iteration it is below the divisor, so bit 16 is always 0.
  assign s_val  = {r_reg, q_reg[15]};
  assign t_val  = bla_sub(s_val, {1'b0, b_reg});
  assign q_next = {q_reg[14:0], ~t_val[16]};
  assign r_next = t_val[16] ? s_val[15:0] : t_val[15:0];

`ifdef DIV_ZERO_TRAP_EN
  logic dbz_reg;
  assign bus.dbz = dbz_reg;
`else
  assign bus.dbz = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = BUSY;
      BUSY: begin
        if (count == 4'd15) state_next = DONE;
`ifdef DIV_ZERO_TRAP_EN
        if (dbz_reg) state_next = DONE;
`endif
      end
      DONE: state_next = bus.start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      quot_reg <= 16'h0000;
      rem_reg  <= 16'h0000;
`ifdef DIV_ZERO_TRAP_EN
      dbz_reg  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept)
        count <= 4'd0;
      else if (state == BUSY)
        count <= count + 4'd1;
`ifdef DIV_ZERO_TRAP_EN
      if (accept)
        dbz_reg <= (bus.divisor == 16'h0000);
      // Zero divisor: Q still holds the untouched dividend on the single BUSY cycle.
      if (state == BUSY && dbz_reg) begin
        quot_reg <= 16'hFFFF;
        rem_reg  <= q_reg;
      end else if (last_iter) begin
        quot_reg <= q_next;
        rem_reg  <= r_next;
      end
`else
      if (last_iter) begin
        quot_reg <= q_next;
        rem_reg  <= r_next;
      end
`endif
    end
  end

  // Datapath registers carry no reset; they are always loaded on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      b_reg <= bus.divisor;
      q_reg <= bus.dividend;
      r_reg <= 16'h0000;
    end else if (state == BUSY) begin
      q_reg <= q_next;
      r_reg <= r_next;
    end
  end

  assign bus.busy      = (state == BUSY);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quot_reg;
  assign bus.remainder = rem_reg;

endmodule

// File: tb/tb_div_bla_16.sv
// Directed self-checking bench for div_bla_16 (both DIV_ZERO_TRAP_EN builds).
module tb_div_bla_16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  bit   busy_ok;
  bit   extra_done;

  always #5 clk = ~clk;

  div_bla_16_if bus ();

  div_bla_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Counts edges until done, bounded; busy must be high on every cycle before done and low on it.
  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    do begin
      tick();
      n++;
      if (!bus.done && !bus.busy) ok = 1'b0;
    end while (!bus.done && n < 40);
    if (bus.done && bus.busy) ok = 1'b0;
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] eq, input logic [15:0] er, input int lat);
    launch(a, b);
    wait_done(cyc, busy_ok);
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor  = 16'h0000;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_q", bus.quotient, 16'h0000);
    check("rst_r", bus.remainder, 16'h0000);
    check("rst_dbz", bus.dbz, 1'b0);
    rst = 1'b0;
    tick();

    launch(16'd100, 16'd7);
    check("basic_busy_n", bus.busy, 1'b1);
    wait_done(cyc, busy_ok);
    check("basic_lat", cyc, 16);
    check("basic_busy", busy_ok, 1'b1);
    check("basic_done", bus.done, 1'b1);
    check("basic_q", bus.quotient, 16'd14);
    check("basic_r", bus.remainder, 16'd2);
    check("basic_dbz", bus.dbz, 1'b0);
    tick();
    check("basic_done_pulse", bus.done, 1'b0);
    check("basic_q_hold", bus.quotient, 16'd14);

    op("max_by_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16);
    op("small_by_max", 16'h0003, 16'hFFFF, 16'h0000, 16'h0003, 16);
    op("max_by_max", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 16);

`ifdef DIV_ZERO_TRAP_EN
    op("dbz", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1);
    check("dbz_flag", bus.dbz, 1'b1);
    tick();
    tick();
    check("dbz_hold", bus.dbz, 1'b1);
    op("after_dbz", 16'd45, 16'd6, 16'd7, 16'd3, 16);
    check("dbz_cleared", bus.dbz, 1'b0);
`else
    op("dbz", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 16);
    check("dbz_flag", bus.dbz, 1'b0);
`endif

    // New start mid-run must be ignored.
    launch(16'd100, 16'd7);
    cyc = 0;
    for (int i = 1; i < 5; i++) begin
      tick();
      cyc++;
    end
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    bus.start    = 1'b1;
    tick();
    cyc++;
    bus.start = 1'b0;
    while (!bus.done && cyc < 40) begin
      tick();
      cyc++;
    end
    check("ignore_lat", cyc, 16);
    check("ignore_q", bus.quotient, 16'd14);
    check("ignore_r", bus.remainder, 16'd2);
    extra_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) extra_done = 1'b1;
    end
    check("ignore_single_done", extra_done, 1'b0);

    // Asynchronous reset in the middle of a run.
    launch(16'd100, 16'd7);
    for (int i = 1; i < 8; i++) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_q", bus.quotient, 16'h0000);
    check("midrst_r", bus.remainder, 16'h0000);
    tick();
    rst = 1'b0;
    extra_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) extra_done = 1'b1;
    end
    check("midrst_no_done", extra_done, 1'b0);
    op("after_rst", 16'd9, 16'd3, 16'd3, 16'd0, 16);
    tick();

    // Back-to-back: start held through the DONE cycle.
    launch(16'd100, 16'd7);
    wait_done(cyc, busy_ok);
    check("b2b_first_lat", cyc, 16);
    check("b2b_first_q", bus.quotient, 16'd14);
    check("b2b_first_r", bus.remainder, 16'd2);
    launch(16'd200, 16'd9);
    check("b2b_done_fall", bus.done, 1'b0);
    check("b2b_busy_rise", bus.busy, 1'b1);
    wait_done(cyc, busy_ok);
    check("b2b_second_lat", cyc + 1, 17);
    check("b2b_second_busy", busy_ok, 1'b1);
    check("b2b_second_q", bus.quotient, 16'd22);
    check("b2b_second_r", bus.remainder, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
